// File: rtl/harvard_sequencer.sv
// harvard_sequencer: fetch/execute control unit and ALU for the Harvard machine.
// Define HARVARD_SEQ_SINGLE_STEP_EN to add a STEP input that gates each instruction.
module harvard_sequencer #(
  parameter int PC_W = 8,
  parameter int I_W = 22,
  parameter int D_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
`ifdef HARVARD_SEQ_SINGLE_STEP_EN
  input  logic            STEP,
`endif
  output logic [PC_W-1:0] PC,
  input  logic [I_W-1:0]  I,
  output logic [D_W-1:0]  DW,
  output logic [D_W-1:0]  OR,
  output logic [D_W-1:0]  data,
  output logic            D_we,
  input  logic [D_W-1:0]  DR,
  output logic [D_W-1:0]  AW,
  output logic            A_we,
  input  logic [D_W-1:0]  AR,
  output logic            EFW,
  output logic            CFW,
  input  logic            EFF,
  input  logic            CFF,
  output logic            BUSY,
  output logic            HALTED
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_WAIT} state_t;
  localparam logic [3:0] OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4,
                         OP_AND = 4'h5, OP_OR = 4'h6, OP_LDI = 4'h7, OP_JMP = 4'h8,
                         OP_JZ = 4'h9, OP_JC = 4'hA, OP_HLT = 4'hF;
  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [I_W-1:0]  r_ir;
  logic            r_efw, r_cfw, r_busy, r_halted;
  logic [3:0]      w_op;
  logic [D_W-1:0]  w_opd, w_res;
  logic [D_W:0]    w_add, w_sub;
  logic            w_exec, w_acc_op, w_carry, w_taken, w_unused;
  logic [PC_W-1:0] w_pc_next;
  assign w_op   = r_ir[I_W-1:I_W-4];
  assign w_opd  = r_ir[D_W-1:0];
  assign w_unused = ^r_ir[I_W-5:D_W];
  assign w_exec = (r_state == S_EXEC);
  // top bit of the extended difference is the unsigned borrow
  assign w_add  = {1'b0, AR} + {1'b0, DR};
  assign w_sub  = {1'b0, AR} - {1'b0, DR};
  assign w_carry = (w_op == OP_ADD) ? w_add[D_W] : w_sub[D_W];
  assign w_res  = (w_op == OP_LDA) ? DR :
                  (w_op == OP_ADD) ? w_add[D_W-1:0] :
                  (w_op == OP_SUB) ? w_sub[D_W-1:0] :
                  (w_op == OP_AND) ? (AR & DR) :
                  (w_op == OP_OR)  ? (AR | DR) :
                  (w_op == OP_LDI) ? w_opd : '0;
  assign w_acc_op = (w_op == OP_LDA) || (w_op == OP_ADD) || (w_op == OP_SUB) ||
                    (w_op == OP_AND) || (w_op == OP_OR) || (w_op == OP_LDI);
  assign w_taken = (w_op == OP_JMP) || ((w_op == OP_JZ) && EFF) || ((w_op == OP_JC) && CFF);
  assign w_pc_next = w_taken ? w_opd[PC_W-1:0] : r_pc + 1'b1;
  assign PC     = r_pc;
  assign DW     = w_opd;
  assign OR     = w_opd;
  assign data   = AR;
  assign AW     = w_res;
  assign A_we   = w_exec && !RST && w_acc_op;
  assign D_we   = w_exec && !RST && (w_op == OP_STA);
  assign EFW    = r_efw;
  assign CFW    = r_cfw;
  assign BUSY   = r_busy;
  assign HALTED = r_halted;
  always_ff @(posedge CLK)
    if (RST) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_efw    <= 1'b0;
      r_cfw    <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else
      case (r_state)
        S_IDLE, S_HALT:
          if (START) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        S_FETCH: begin
          r_ir    <= I;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_acc_op) r_efw <= (w_res == '0);
          if ((w_op == OP_ADD) || (w_op == OP_SUB)) r_cfw <= w_carry;
          if (w_op == OP_HLT) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_pc <= w_pc_next;
`ifdef HARVARD_SEQ_SINGLE_STEP_EN
            r_state <= S_WAIT;
`else
            r_state <= S_FETCH;
`endif
          end
        end
`ifdef HARVARD_SEQ_SINGLE_STEP_EN
        S_WAIT: if (STEP) r_state <= S_FETCH;
`endif
        default: r_state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_harvard_sequencer.sv
// tb_harvard_sequencer: directed and random programs checked against an instruction-level model.
module tb_harvard_sequencer;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0]  pc;
  logic [21:0] ins;
  logic [15:0] dw, or_a, wdata, aw, dr;
  logic [15:0] acc = '0;
  logic        d_we, a_we, efw, cfw, busy, halted;
  logic        eff = 1'b0, cff = 1'b0;
  logic [21:0] imem [256];
  logic [15:0] dmem [256];
  logic [15:0] m_dmem [256];
  logic [7:0]  m_pc;
  logic [15:0] m_acc;
  logic        m_ef, m_cf;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  // passive environment: memories, accumulator and status register
  assign ins = imem[pc];
  assign dr  = dmem[or_a[7:0]];
  always @(posedge clk) begin
    if (a_we) acc <= aw;
    if (d_we) dmem[dw[7:0]] <= wdata;
    eff <= efw;
    cff <= cfw;
  end

  harvard_sequencer dut (
    .CLK(clk), .RST(rst), .START(start), .PC(pc), .I(ins),
    .DW(dw), .OR(or_a), .data(wdata), .D_we(d_we), .DR(dr),
    .AW(aw), .A_we(a_we), .AR(acc), .EFW(efw), .CFW(cfw),
    .EFF(eff), .CFF(cff), .BUSY(busy), .HALTED(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] enc(input logic [3:0] op, input logic [15:0] opd);
    return {op, 2'b00, opd};
  endfunction

  // runs one instruction starting at a negedge inside FETCH, ends at the negedge of the next cycle
  task automatic instr();
    logic [21:0] w;
    logic [3:0]  op;
    logic [15:0] opd, d, res;
    logic [16:0] s;
    logic        wa, wd;
    w = imem[m_pc]; op = w[21:18]; opd = w[15:0]; d = m_dmem[opd[7:0]];
    res = '0; wa = 1'b0; wd = 1'b0; s = '0;
    chk("fetch_busy", busy, 1);
    chk("fetch_pc", pc, m_pc);
    chk("fetch_we", {a_we, d_we}, 0);
    @(negedge clk);
    case (op)
      4'h1: begin res = d; wa = 1'b1; end
      4'h2: wd = 1'b1;
      4'h3: begin s = {1'b0, m_acc} + {1'b0, d}; res = s[15:0]; wa = 1'b1; m_cf = s[16]; end
      4'h4: begin res = m_acc - d; wa = 1'b1; m_cf = (m_acc < d); end
      4'h5: begin res = m_acc & d; wa = 1'b1; end
      4'h6: begin res = m_acc | d; wa = 1'b1; end
      4'h7: begin res = opd; wa = 1'b1; end
      default: ;
    endcase
    chk("exec_busy", busy, 1);
    chk("exec_a_we", a_we, wa);
    chk("exec_d_we", d_we, wd);
    if (wa) chk("exec_aw", aw, res);
    if (wd) begin
      chk("sta_addr", dw, opd);
      chk("sta_data", wdata, m_acc);
      m_dmem[opd[7:0]] = m_acc;
    end
    if (wa) begin m_acc = res; m_ef = (res == 16'h0); end
    case (op)
      4'h8: m_pc = opd[7:0];
      4'h9: m_pc = m_ef ? opd[7:0] : m_pc + 8'd1;
      4'hA: m_pc = m_cf ? opd[7:0] : m_pc + 8'd1;
      4'hF: ;
      default: m_pc = m_pc + 8'd1;
    endcase
    @(negedge clk);
    chk("efw", efw, m_ef);
    chk("cfw", cfw, m_cf);
    chk("pc_next", pc, m_pc);
    chk("halted", halted, op == 4'hF);
    chk("acc", acc, m_acc);
    if (wd) chk("dmem_write", dmem[opd[7:0]], m_acc);
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 256; i++) begin
      v = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      dmem[i] = v; m_dmem[i] = v; imem[i] = '0;
    end
    dmem[16] = 16'h0001; m_dmem[16] = 16'h0001;
    imem[8'h00] = enc(4'h7, 16'h1234);
    imem[8'h01] = enc(4'h7, 16'hFFFF);
    imem[8'h02] = enc(4'h3, 16'h0010);
    imem[8'h03] = enc(4'h9, 16'h0020);
    imem[8'h20] = enc(4'hA, 16'h0030);
    imem[8'h30] = enc(4'h7, 16'hBEEF);
    imem[8'h31] = enc(4'h2, 16'h0005);
    imem[8'h32] = enc(4'h8, 16'h00FF);
    imem[8'hFF] = enc(4'hC, 16'h1111);
    imem[8'h06] = enc(4'h0, 16'h0000);
    imem[8'h07] = enc(4'hF, 16'h0000);
    m_pc = 8'h00; m_acc = 16'h0; m_ef = 1'b0; m_cf = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_flags", {efw, cfw}, 0);
    chk("rst_we", {a_we, d_we}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) instr();
    imem[8'h00] = enc(4'h8, 16'h0006);
    repeat (4) instr();
    repeat (10) begin
      @(negedge clk);
      chk("halt_pc", pc, 8'h07);
      chk("halt_flag", halted, 1);
      chk("halt_busy", busy, 0);
    end
    for (int i = 0; i < 256; i++) imem[i] = enc(4'($urandom_range(0, 14)), 16'($urandom));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc = 8'h00;
    repeat (150) begin
      start = 1'($urandom_range(0, 1));
      instr();
    end
    start = 1'b0;
    imem[m_pc] = enc(4'h2, 16'h0005);
    @(negedge clk);
    chk("rst_exec_pre_dwe", d_we, 1);
    rst = 1'b1;
    #1;
    chk("rst_exec_dwe", d_we, 0);
    chk("rst_exec_awe", a_we, 0);
    @(negedge clk);
    chk("rst_exec_pc", pc, 0);
    chk("rst_exec_busy", busy, 0);
    chk("rst_exec_flags", {efw, cfw}, 0);
    chk("rst_exec_nowrite", dmem[5], m_dmem[5]);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_idle", {busy, halted}, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/harvard_sequencer.md
Name: harvard_sequencer

Overview:
- Control unit for the Harvard machine. It runs a two-state fetch/execute loop over the instruction memory (8-bit PC, 22-bit instruction word).
- It drives the address and write-enable of the data memory and the accumulator, and holds the EF/CF values presented to the status register.
- It contains the ALU. The memories and the status register stay passive storage.

Parameters:
- PC_W, 8, program counter width; wraps modulo 2^PC_W.
- I_W, 22, instruction width. Field layout: opcode I[21:18], unused I[17:16], operand I[15:0].
- D_W, 16, data, accumulator and address width.
- RESET_PC, 0, PC value on reset, START and restart.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous reset, active-high.
- START  in  1  level; sampled only in IDLE and HALT.
- PC  out  PC_W  instruction memory address (registered).
- I  in  I_W  instruction memory read data; asynchronous, valid in the same cycle as PC.
- DW  out  D_W  data memory write address; equals IR operand.
- OR  out  D_W  data memory read address; equals IR operand.
- data  out  D_W  data memory write data; equals AR.
- D_we  out  1  data memory write enable.
- DR  in  D_W  data memory read data; asynchronous.
- AW  out  D_W  accumulator write data; equals ALU result.
- A_we  out  1  accumulator write enable.
- AR  in  D_W  accumulator value.
- EFW  out  1  zero flag to the status register (registered, held).
- CFW  out  1  carry flag to the status register (registered, held).
- EFF  in  1  stored zero flag.
- CFF  in  1  stored carry flag.
- BUSY  out  1  high in FETCH and EXEC.
- HALTED  out  1  high in HALT.

Behaviour:
- Reset values: state=IDLE, PC=RESET_PC, IR=0, EFW=0, CFW=0, BUSY=0, HALTED=0. D_we and A_we are gated by RST, so no write happens on any edge where RST=1, including a reset arriving mid-EXEC.
- States:
  - IDLE: waits; on START go to FETCH with PC=RESET_PC.
  - FETCH: IR<=I; go to EXEC.
  - EXEC: perform the opcode and update PC; go to FETCH, or HALT on HLT.
  - HALT: PC frozen; on START go to FETCH with PC=RESET_PC and flags unchanged.
- Each instruction takes exactly 2 cycles. START is ignored in FETCH and EXEC.
- DW and OR are driven combinationally from IR[15:0]. D_we and A_we are asserted only in EXEC (combinational), for exactly one cycle.
- Opcodes (IR[21:18]):
  - 0 NOP: no effect.
  - 1 LDA: AW=DR, A_we; EFW<=(DR==0).
  - 2 STA: D_we; D[addr]<=AR. Flags unchanged.
  - 3 ADD: {c,AW}=AR+DR (D_W+1 bits); A_we; CFW<=c; EFW<=(AW==0).
  - 4 SUB: AW=AR-DR; A_we; CFW<=borrow (AR<DR unsigned); EFW<=(AW==0).
  - 5 AND, 6 OR: bitwise; A_we; EFW updated; CFW unchanged.
  - 7 LDI: AW=IR[15:0]; A_we; EFW updated.
  - 8 JMP: PC<=IR[PC_W-1:0].
  - 9 JZ: branch if EFF=1. A JC: branch if CFF=1.
  - B-E reserved: execute as NOP.
  - F HLT: go to HALT; PC not incremented.
- Non-taken branches and all other non-HLT ops: PC<=PC+1 in EXEC, wrapping 2^PC_W-1 to 0.
- Flag timing: EFW/CFW register at the end of EXEC. The status register latches them at the end of the following FETCH, so JZ/JC always see the flags of the previous flag-setting instruction.
- EFW and CFW hold their value at all other times, because the status register latches them every cycle.

Optional Feature:
- Macro HARVARD_SEQ_SINGLE_STEP_EN adds an input STEP (1 bit) and state WAIT_STEP.
- With the macro: EXEC goes to WAIT_STEP instead of FETCH. WAIT_STEP goes to FETCH on the first cycle STEP=1. BUSY stays high in WAIT_STEP. RST returns to IDLE from WAIT_STEP.
- Without the macro: no STEP port and continuous execution.

Test Plan:
- Reset then START: PC=0x00 and BUSY rises one cycle after START; with I=LDI 0x1234 at PC0, A_we pulses in cycle 3 with AW=0x1234; PC=0x01.
- ADD overflow: AR=0xFFFF, DR=0x0001 -> AW=0x0000, CFW=1, EFW=1; a following JZ 0x20 and JC 0x30 take PC to 0x20, then JC at 0x20 takes PC to 0x30.
- STA 0x0005 with AR=0xBEEF: D_we high for exactly one EXEC cycle, DW=0x0005, data=0xBEEF; A_we stays 0; flags hold.
- PC wrap: NOP at PC=0xFF -> next PC=0x00. Reserved opcode 0xC behaves as NOP.
- HLT at PC=0x07: HALTED=1, PC stays 0x07 for 10 cycles; START -> PC=0x00, BUSY=1.
- RST asserted during EXEC of STA: no D_we on that edge; next cycle IDLE with PC=0x00, EFW=CFW=0.
